// File: rtl/count_seq_monitor_if.sv
`timescale 1ns/1ps
// count_seq_monitor_if
// Bundles the observed counter signals and the monitor's status outputs.
//   count_in       : counter value under observation
//   sample_en      : take a sample on this edge
//   upstream_reset : level copy of the observed counter's reset
//   locked         : sequence verified
//   err_pulse      : one-cycle increment violation while locked
//   wrap_pulse     : one-cycle legal wrap while locked
//   err_count      : saturating error count
//   wrap_count     : wrap count, modulo 2^WRAP_W
// master = stimulus/counter side, slave = monitor.
interface count_seq_monitor_if #(
    parameter int W      = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic [W-1:0]      count_in;
    logic              sample_en;
    logic              upstream_reset;
    logic              locked;
    logic              err_pulse;
    logic              wrap_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output count_in, sample_en, upstream_reset,
        input  locked, err_pulse, wrap_pulse, err_count, wrap_count
    );

    modport slave (
        input  count_in, sample_en, upstream_reset,
        output locked, err_pulse, wrap_pulse, err_count, wrap_count
    );
endinterface

// File: rtl/count_seq_monitor.sv
`timescale 1ns/1ps
// count_seq_monitor
// Checks that a free-running W-bit up-counter advances by exactly +1 mod 2^W
// on every enabled sample. Hunts for a starting value, requires LOCK_LEN
// consecutive correct increments to lock, then reports wraps and errors.
// A return to zero while the counter's own reset is high is legal.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : count_seq_monitor_if.slave (inputs count_in/sample_en/
//           upstream_reset, registered outputs locked/err_pulse/wrap_pulse/
//           err_count/wrap_count)
module count_seq_monitor #(
    parameter int W        = 4,
    parameter int LOCK_LEN = 3,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    count_seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t            state, state_n;
    logic [W-1:0]      prev, prev_n;
    logic [3:0]        good_run, good_run_n;
    logic              locked, locked_n;
    logic              err_p, err_p_n;
    logic              wrap_p, wrap_p_n;
    logic [ERR_W-1:0]  err_count, err_count_n;
    logic [WRAP_W-1:0] wrap_count, wrap_count_n;

    logic [W-1:0] s;
    logic         good;
    logic         legal_zero;

    assign s = bus.count_in;
    // A nonzero sample while the counter is held in reset can never be good,
    // even if it happens to equal prev+1.
    assign good       = (s == prev + W'(1)) && !bus.upstream_reset;
    assign legal_zero = bus.upstream_reset && (s == '0);

    always_comb begin
        state_n      = state;
        prev_n       = prev;
        good_run_n   = good_run;
        locked_n     = locked;
        err_p_n      = 1'b0;
        wrap_p_n     = 1'b0;
        err_count_n  = err_count;
        wrap_count_n = wrap_count;
        if (bus.sample_en) begin
            prev_n = s;
            if (legal_zero) begin
                // Counter was reset: resynchronise silently, no wrap either.
                good_run_n = '0;
                state_n    = SYNC;
                locked_n   = 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        good_run_n = '0;
                        state_n    = SYNC;
                    end
                    SYNC: begin
                        if (good) begin
                            good_run_n = good_run + 4'd1;
                            if (good_run == 4'(LOCK_LEN - 1)) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                            end
                        end else begin
                            good_run_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            if (prev == '1) begin
                                wrap_p_n     = 1'b1;
                                wrap_count_n = wrap_count + WRAP_W'(1);
                            end
                        end else begin
                            err_p_n    = 1'b1;
                            good_run_n = '0;
                            state_n    = SYNC;
                            locked_n   = 1'b0;
                            if (err_count != '1)
                                err_count_n = err_count + ERR_W'(1);
                        end
                    end
                    default: begin
                        state_n  = HUNT;
                        locked_n = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            prev       <= '0;
            good_run   <= '0;
            locked     <= 1'b0;
            err_p      <= 1'b0;
            wrap_p     <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            good_run   <= good_run_n;
            locked     <= locked_n;
            err_p      <= err_p_n;
            wrap_p     <= wrap_p_n;
            err_count  <= err_count_n;
            wrap_count <= wrap_count_n;
        end
    end

    assign bus.locked     = locked;
    assign bus.err_pulse  = err_p;
    assign bus.wrap_pulse = wrap_p;
    assign bus.err_count  = err_count;
    assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_count_seq_monitor.sv
`timescale 1ns/1ps
// Directed bench for count_seq_monitor (W=4, LOCK_LEN=3, ERR_W=2 so that
// error-count saturation is reachable). Stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops one entry after every
// clock edge that followed a pushed sample and compares.
module tb_count_seq_monitor;
    localparam int W = 4, LOCK_LEN = 3, WRAP_W = 8, ERR_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_seq_monitor_if #(.W(W), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

    count_seq_monitor #(.W(W), .LOCK_LEN(LOCK_LEN), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int id, lk, ep, wp, ec, wc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int vec_id = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lk, ep, wp, ec, wc);
        chk({tag, " locked"},     int'(bus.locked),     lk);
        chk({tag, " err_pulse"},  int'(bus.err_pulse),  ep);
        chk({tag, " wrap_pulse"}, int'(bus.wrap_pulse), wp);
        chk({tag, " err_count"},  int'(bus.err_count),  ec);
        chk({tag, " wrap_count"}, int'(bus.wrap_count), wc);
    endtask

    // Drive one sample at the falling edge and queue the outputs expected
    // after the following rising edge.
    task automatic step(input int s, en, ur, lk, ep, wp, ec, wc);
        exp_t e;
        @(negedge clk);
        bus.count_in       = W'(s);
        bus.sample_en      = 1'(en);
        bus.upstream_reset = 1'(ur);
        vec_id++;
        e.id = vec_id; e.lk = lk; e.ep = ep; e.wp = wp; e.ec = ec; e.wc = wc;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all($sformatf("v%0d", e.id), e.lk, e.ep, e.wp, e.ec, e.wc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.count_in = '0; bus.sample_en = 1'b0; bus.upstream_reset = 1'b0;
        #3;
        chk_all("por", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Hunt, sync, lock on 3, run to 15, legal wrap to 0.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(2, 1, 0, 0, 0, 0, 0, 0);
        step(3, 1, 0, 1, 0, 0, 0, 0);
        for (int v = 4; v <= 15; v++) step(v, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 0, 0, 1);

        // Jump error 6 -> 9, relock on 12.
        for (int v = 2; v <= 6; v++) step(v, 1, 0, 1, 0, 0, 0, 1);
        step(9,  1, 0, 0, 1, 0, 1, 1);
        step(10, 1, 0, 0, 0, 0, 1, 1);
        step(11, 1, 0, 0, 0, 0, 1, 1);
        step(12, 1, 0, 1, 0, 0, 1, 1);
        for (int v = 13; v <= 15; v++) step(v, 1, 0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 1, 0, 1, 1, 2);
        for (int v = 1; v <= 7; v++) step(v, 1, 0, 1, 0, 0, 1, 2);

        // Counter reset back to 0 is legal; a nonzero sample under reset is an error.
        step(0, 1, 1, 0, 0, 0, 1, 2);
        step(1, 1, 0, 0, 0, 0, 1, 2);
        step(2, 1, 0, 0, 0, 0, 1, 2);
        step(3, 1, 0, 1, 0, 0, 1, 2);
        step(4, 1, 1, 0, 1, 0, 2, 2);
        step(9, 0, 0, 0, 0, 0, 2, 2);   // pulse drops while disabled
        step(5, 1, 0, 0, 0, 0, 2, 2);
        step(6, 1, 0, 0, 0, 0, 2, 2);
        step(7, 1, 0, 1, 0, 0, 2, 2);

        // Enable gating: garbage while disabled is ignored.
        for (int i = 0; i < 5; i++) step(9, 0, 0, 1, 0, 0, 2, 2);
        step(8, 1, 0, 1, 0, 0, 2, 2);

        // Asynchronous reset between edges while locked with err_count = 2.
        @(negedge clk);
        bus.sample_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // First sample enters SYNC; a bad sample in SYNC raises nothing.
        step(5, 1, 0, 0, 0, 0, 0, 0);
        step(6, 1, 0, 0, 0, 0, 0, 0);
        step(3, 1, 0, 0, 0, 0, 0, 0);
        step(4, 1, 0, 0, 0, 0, 0, 0);
        step(5, 1, 0, 0, 0, 0, 0, 0);
        step(6, 1, 0, 1, 0, 0, 0, 0);

        // Saturation with ERR_W = 2: counts 1, 2, 3, 3, 3, pulse every time.
        step(6,  1, 0, 0, 1, 0, 1, 0);
        step(7,  1, 0, 0, 0, 0, 1, 0);
        step(8,  1, 0, 0, 0, 0, 1, 0);
        step(9,  1, 0, 1, 0, 0, 1, 0);
        step(9,  1, 0, 0, 1, 0, 2, 0);
        step(10, 1, 0, 0, 0, 0, 2, 0);
        step(11, 1, 0, 0, 0, 0, 2, 0);
        step(12, 1, 0, 1, 0, 0, 2, 0);
        step(12, 1, 0, 0, 1, 0, 3, 0);
        step(13, 1, 0, 0, 0, 0, 3, 0);
        step(14, 1, 0, 0, 0, 0, 3, 0);
        step(15, 1, 0, 1, 0, 0, 3, 0);
        step(15, 1, 0, 0, 1, 0, 3, 0);
        step(0,  1, 0, 0, 0, 0, 3, 0);  // 15 -> 0 while not locked: no wrap
        step(1,  1, 0, 0, 0, 0, 3, 0);
        step(2,  1, 0, 1, 0, 0, 3, 0);
        step(2,  1, 0, 0, 1, 0, 3, 0);

        @(negedge clk);
        bus.sample_en = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream checker for the free-running W-bit up-counter.
- Samples the counter's output every enabled clock and verifies it advances by exactly +1 mod 2^W.
- Maintains lock status, wrap and error statistics, and emits one-cycle event pulses.
- Knows about the counter's own reset so a legal return to zero is not flagged as an error.

Parameters:
- W, 4, width of monitored count.
- LOCK_LEN, 3, consecutive correct increments required to declare lock (range 1..15).
- WRAP_W, 8, width of wrap counter.
- ERR_W, 8, width of error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- count_in  in  W  counter output under observation.
- sample_en  in  1  1 = sample count_in on this edge; 0 = freeze all state.
- upstream_reset  in  1  level copy of the counter's reset input; while high the only legal sample is 0.
- locked  out  1  sequence verified; high in LOCKED state.
- err_pulse  out  1  one-cycle pulse, increment violation while locked.
- wrap_pulse  out  1  one-cycle pulse, legal 2^W-1 -> 0 transition while locked.
- err_count  out  ERR_W  saturating count of err_pulse events.
- wrap_count  out  WRAP_W  wrap events, modulo 2^WRAP_W.

Behaviour:
- Reset (async, any time, including mid-run):
  - state = HUNT, prev = 0, good_run = 0.
  - All outputs = 0 immediately, without waiting for a clock edge.
- All outputs are registered; latency 1 (response visible after the edge that took the sample).
- sample_en = 0: no state change. err_pulse and wrap_pulse drop to 0; counters and locked hold.
- Sample S with sample_en = 1 and upstream_reset = 0; "good" means S == (prev + 1) mod 2^W:
  - HUNT: prev <= S; good_run <= 0; -> SYNC.
  - SYNC, good: prev <= S; good_run++. If good_run + 1 == LOCK_LEN -> LOCKED, locked <= 1.
  - SYNC, not good: prev <= S; good_run <= 0. No error is raised.
  - LOCKED, good: prev <= S. If prev == 2^W-1 (so S == 0): wrap_pulse <= 1, wrap_count++ (wraps to 0).
  - LOCKED, not good, including a hold (S == prev): err_pulse <= 1; err_count++ saturating at 2^ERR_W-1; prev <= S; good_run <= 0; -> SYNC; locked <= 0.
- Sample with sample_en = 1 and upstream_reset = 1:
  - S == 0: prev <= 0; good_run <= 0; -> SYNC; locked <= 0. No err, no wrap, even if coming from LOCKED.
  - S != 0: handled as a not-good sample under the current-state rules above.
- Simultaneous events:
  - A wrap and an error cannot occur on the same sample.
  - upstream_reset takes priority over wrap detection.
- Pulses are never stretched. Back-to-back qualifying samples give back-to-back pulses.

Test Plan:
- Async reset mid-run: assert reset between edges while locked with err_count = 2 -> all outputs 0 before the next edge; first sample afterwards enters SYNC.
- Lock and wrap: reset released, sample_en = 1, samples 0,1,2,3 -> locked = 1 after the edge sampling 3. Continue to 15, then 0 -> wrap_pulse for one cycle, wrap_count = 1, err_count = 0.
- Jump error: locked, samples 5,6,9 -> err_pulse after the 9 edge, err_count = 1, locked = 0. Then 10,11,12 -> locked = 1 after the 12 edge.
- Counter reset: locked at sample 7, upstream_reset = 1 with sample 0 -> no err_pulse, locked = 0. Release, samples 1,2,3 -> relocked. Repeat with upstream_reset = 1 and sample 4 -> err_pulse, err_count++.
- Enable gating: locked at 4; sample_en = 0 for 5 cycles while count_in shows 9 -> no state change. Re-enable with sample 5 -> still locked, no error.
- Saturation: ERR_W = 2, force 5 lock/error cycles -> err_count increments 1, 2, 3, 3, 3, with err_pulse still asserted each time.
